// File: rtl/sram_march_tester_pkg.sv
// rtl/sram_march_tester_pkg.sv - shared types, phase codes and data pattern for the march tester
package sram_test_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] PH_WR  = 2'd0;
  localparam logic [1:0] PH_RD  = 2'd1;
  localparam logic [1:0] PH_WRN = 2'd2;
  localparam logic [1:0] PH_RDN = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, CHECK, NEXT, FINISH} state_t;

  // Callers narrow the result to their data width, which also truncates the address.
  function automatic logic [63:0] pattern(input logic [63:0] a, input logic [63:0] seed);
    return a ^ seed;
  endfunction

endpackage

// File: rtl/sram_march_tester_if.sv
// rtl/sram_march_tester_if.sv - request/response port between a tester and the SRAM controller
interface sram_march_tester_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              mem;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_f2s;
  logic              ready;
  logic [DATA_W-1:0] data_s2f;

  modport master (output mem, rw, addr, data_f2s, input ready, data_s2f);
  modport slave  (input mem, rw, addr, data_f2s, output ready, data_s2f);
endinterface

// File: rtl/sram_march_tester_req_port.sv
// rtl/sram_march_tester_req_port.sv - one-access-at-a-time handshake engine for SRAM masters
module sram_req_port
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              accepted,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  sram_march_tester_if.master bus
);

  state_t            state, state_nxt;
  logic              mem_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // mem follows the previous cycle's ready, so the strobe never depends combinationally on ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mem_q  <= 1'b0;
      rw_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          mem_q <= 1'b0;
          if (req) begin
            rw_q   <= req_rw;
            addr_q <= req_addr;
            data_q <= req_rw ? '0 : req_wdata;
          end
        end
        ISSUE:   mem_q <= accepted ? 1'b0 : bus.ready;
        default: mem_q <= 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    accepted    = 1'b0;
    rdata_valid = 1'b0;
    case (state)
      IDLE:  if (req) state_nxt = ISSUE;
      ISSUE: if (mem_q && bus.ready) begin
        accepted  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:  state_nxt = WAIT;
      WAIT:  if (bus.ready) begin
        rdata_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem      = mem_q;
  assign bus.rw       = rw_q;
  assign bus.addr     = addr_q;
  assign bus.data_f2s = data_q;
  assign rdata        = bus.data_s2f;

endmodule

// File: rtl/sram_march_tester.sv
// rtl/sram_march_tester.sv - four-phase march sequencer that checks an SRAM through its controller
module sram_march_tester
  import sram_test_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 18'h3FFFF,
  parameter logic [DATA_W-1:0] SEED      = 16'hA5C3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [7:0]        err_count,
  sram_march_tester_if.master bus
);

  state_t            state, state_nxt;
  logic [1:0]        phase;
  logic [ADDR_W-1:0] cur_addr;
  logic              accepted, rdata_valid;
  logic [DATA_W-1:0] rdata, pat, expected;
  logic              is_read, descending, at_end;

  assign is_read    = (phase == PH_RD) || (phase == PH_RDN);
  assign descending = (phase == PH_WRN) || (phase == PH_RDN);
  assign at_end     = descending ? (cur_addr == '0) : (cur_addr == LAST_ADDR);
  assign pat        = DATA_W'(pattern(64'(cur_addr), 64'(SEED)));
  assign expected   = descending ? ~pat : pat;

  sram_req_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
    .clk         (clk),
    .reset       (reset),
    .req         (state == ISSUE),
    .req_rw      (is_read),
    .req_addr    (cur_addr),
    .req_wdata   (expected),
    .accepted    (accepted),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .bus         (bus)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (accepted) state_nxt = HOLD;
      HOLD:    state_nxt = WAIT;
      WAIT:    if (rdata_valid) state_nxt = is_read ? CHECK : NEXT;
      CHECK:   state_nxt = NEXT;
      NEXT:    state_nxt = (at_end && phase == PH_RDN) ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= PH_WR;
      cur_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_addr  <= '0;
      err_data  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          phase     <= PH_WR;
          cur_addr  <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          err_addr  <= '0;
          err_data  <= '0;
          err_count <= '0;
        end
        CHECK: if (rdata != expected) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (err_count == 8'd0) begin
            err_addr <= cur_addr;
            err_data <= rdata;
          end
        end
        NEXT: begin
          // Phase ends clamp the address so it never wraps past 0 or LAST_ADDR.
          if (at_end) begin
            if (phase != PH_RDN) begin
              phase    <= phase + 2'd1;
              cur_addr <= (phase == PH_WR) ? '0 : LAST_ADDR;
            end
          end else begin
            cur_addr <= descending ? cur_addr - 1'b1 : cur_addr + 1'b1;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == 8'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_march_tester.sv
// tb/tb_sram_march_tester.sv - scoreboard bench with a behavioural SRAM controller and march reference model
module tb_sram_march_tester;

  localparam int          LAST = 127;
  localparam logic [15:0] SEED = 16'hA5C3;

  typedef struct packed {logic rw; logic [17:0] addr; logic [15:0] data;} cmd_t;
  typedef struct packed {logic pass; logic [7:0] cnt; logic [17:0] addr; logic [15:0] data;} res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [17:0] err_addr;
  logic [15:0] err_data;
  logic [7:0]  err_count;

  sram_march_tester_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  sram_march_tester #(.ADDR_W(18), .DATA_W(16), .LAST_ADDR(18'(LAST)), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_addr  (err_addr),
    .err_data  (err_data),
    .err_count (err_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_pass = 0, n_total = 0;
  cmd_t cmd_q[$];
  res_t res_q[$];
  int   accepts = 0, mem_pulses = 0, mem_viol = 0;
  int   fault = 0, f_addr = 0, f_bit = 0;
  int   dmin = 1, dmax = 4;
  logic [15:0] sram [0:LAST];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(a) ^ SEED;
  endfunction

  function automatic logic [15:0] store_val(input int a, input logic [15:0] d);
    logic [15:0] r = d;
    if (fault == 1 && a == f_addr) r[f_bit] = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] read_val(input logic [15:0] d);
    return (fault == 2) ? ~d : d;
  endfunction

  // Reference: walk the four phases as plain loops over a faulty memory array.
  task automatic plan_run();
    logic [15:0] ref_mem [0:LAST];
    int          errs = 0;
    res_t        r;
    r = '0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k <= LAST; k++) begin
        int          a;
        logic [15:0] e, obs;
        a = (ph < 2) ? k : LAST - k;
        e = (ph < 2) ? pat(a) : ~pat(a);
        if (ph % 2 == 0) begin
          cmd_q.push_back('{1'b0, 18'(a), e});
          ref_mem[a] = store_val(a, e);
        end else begin
          cmd_q.push_back('{1'b1, 18'(a), 16'h0});
          obs = read_val(ref_mem[a]);
          if (obs != e) begin
            if (errs == 0) begin
              r.addr = 18'(a);
              r.data = obs;
            end
            errs++;
          end
        end
      end
    end
    r.pass = (errs == 0);
    r.cnt  = (errs > 255) ? 8'd255 : 8'(errs);
    res_q.push_back(r);
  endtask

  // Behavioural SRAM controller: accepts on mem&&ready, drops ready for a random spell.
  initial begin
    logic        acc, c_rw;
    logic [17:0] c_a;
    logic [15:0] c_d;
    int          cnt;
    bus.ready    = 1'b1;
    bus.data_s2f = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      acc  = bus.mem && bus.ready;
      c_rw = bus.rw;
      c_a  = bus.addr;
      c_d  = bus.data_f2s;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.ready = 1'b1;
        cnt = 0;
      end else if (acc) begin
        if (c_rw) bus.data_s2f = read_val(sram[c_a]);
        else      sram[c_a] = store_val(int'(c_a), c_d);
        cnt = $urandom_range(dmax, dmin);
        bus.ready = 1'b0;
      end else if (!bus.ready) begin
        cnt--;
        if (cnt <= 0) bus.ready = 1'b1;
      end
    end
  end

  // Monitor: compares every accepted command and every completed run against the queues.
  initial begin
    logic prev_mem = 1'b0, prev_done = 1'b0;
    cmd_t c;
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.mem && !prev_mem) mem_pulses++;
      if (bus.mem && !bus.ready) mem_viol++;
      if (bus.mem && bus.ready) begin
        accepts++;
        if (cmd_q.size() == 0) check("cmd_extra", 64'(bus.addr), 64'h0);
        else begin
          c = cmd_q.pop_front();
          check("cmd", 64'({bus.rw, bus.addr, bus.data_f2s}), 64'(c));
        end
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) check("done_extra", 64'(done), 64'h0);
        else begin
          r = res_q.pop_front();
          check("pass", 64'(pass), 64'(r.pass));
          check("err_count", 64'(err_count), 64'(r.cnt));
          check("err_addr", 64'(err_addr), 64'(r.addr));
          check("err_data", 64'(err_data), 64'(r.data));
          check("busy_at_done", 64'(busy), 64'h0);
        end
      end
      prev_mem  = bus.mem;
      prev_done = done;
    end
  end

  task automatic wait_results(input int left);
    int n = 0;
    while (res_q.size() > left && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("run_timeout", 64'(res_q.size()), 64'(left));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bus"}, 64'({bus.mem, bus.rw, bus.addr, bus.data_f2s}), 64'({1'b0, 1'b1, 34'h0}));
    check({tag, "_status"}, 64'({busy, done, pass, err_addr, err_data, err_count}), 64'h0);
  endtask

  task automatic do_run(input int f, input int fa, input int fb, input int lo, input int hi);
    int p0, v0;
    fault = f; f_addr = fa; f_bit = fb; dmin = lo; dmax = hi;
    plan_run();
    p0 = mem_pulses;
    v0 = mem_viol;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_results(0);
    check("mem_pulses", 64'(mem_pulses - p0), 64'(4 * (LAST + 1)));
    check("mem_without_ready", 64'(mem_viol - v0), 64'h0);
    check("cmds_left", 64'(cmd_q.size()), 64'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, a0, n;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_run(0, 0, 0, 1, 4);
    bad = 0;
    for (int a = 0; a <= LAST; a++) if (sram[a] !== ~pat(a)) bad++;
    check("final_mem_is_inverse", 64'(bad), 64'h0);

    do_run(1, 2, 4, 1, 4);
    do_run(1, $urandom_range(LAST, 0), $urandom_range(15, 0), 1, 4);
    do_run(0, 0, 0, 7, 7);

    // Reset while waiting on a phase-1 read.
    fault = 0; dmin = 7; dmax = 7;
    plan_run();
    a0 = accepts;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    n = 0;
    while (accepts - a0 < LAST + 3 && n < 20000) begin
      @(negedge clk); #1; n++;
    end
    check("reset_mid_reach", 64'(accepts - a0), 64'(LAST + 3));
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset_mid");
    cmd_q.delete();
    res_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    a0 = accepts;
    repeat (20) @(negedge clk);
    check("idle_after_reset", 64'(accepts - a0), 64'h0);

    // Start held high across a whole run, then released during the second one.
    fault = 0; dmin = 1; dmax = 3;
    plan_run();
    plan_run();
    a0 = mem_pulses;
    @(negedge clk); #1 start = 1'b1;
    wait_results(1);
    @(negedge clk);
    check("restart_done_clear", 64'(done), 64'h0);
    check("restart_busy", 64'(busy), 64'h1);
    repeat (20) @(negedge clk);
    #1 start = 1'b0;
    wait_results(0);
    check("held_pulses", 64'(mem_pulses - a0), 64'(8 * (LAST + 1)));

    do_run(2, 0, 0, 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
